// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

    // Index of the hard-wired zero register.
    localparam int REG_ZERO = 0;

    typedef logic [DEF_WIDTH-1:0]  word_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_2r1w_reg_word.sv
// Single storage word with write enable and asynchronous active-low clear.
module reg_word #(
    parameter int WIDTH = regfile_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] word_q;

    // NOTE: non-blocking (<=) for all flop state so every word samples its inputs
    // from before the edge; blocking here would create simulation ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (wr_en_i) begin
            word_q <= wr_data_i;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file, one write port and two registered read ports; r0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a matching read.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        wr_sel = '0;
        if (wr_en && (wr_addr != ZERO_ADDR)) begin
            wr_sel[wr_addr] = 1'b1;
        end
    end

    assign regs[REG_ZERO] = '0;

    // NOTE: storage words are cleared by the async reset; this is intentional,
    // since software relies on every register reading 0 after reset.
    for (genvar i = 1; i < DEPTH; i++) begin : g_word
        reg_word #(.WIDTH(WIDTH)) u_word (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (wr_sel[i]),
            .wr_data_i (wr_data),
            .word_o    (regs[i])
        );
    end

    function automatic logic [WIDTH-1:0] read_word(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] value;
        value = regs[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == addr) && (addr != ZERO_ADDR)) begin
            value = wr_data;
        end
`endif
        return value;
    endfunction

    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic             rd_valid_a_q, rd_valid_b_q;

    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (rd_en_a) rd_data_a_d = read_word(rd_addr_a);
        if (rd_en_b) rd_data_b_d = read_word(rd_addr_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_en_a;
            rd_valid_b_q <= rd_en_b;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed scoreboard bench for regfile_2r1w; expectations come from a local register model.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en_a;
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic        rd_valid_a;
    logic        rd_en_b;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic        rd_valid_b;

    regfile_2r1w dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] data_a;
        logic        valid_a;
        logic [15:0] data_b;
        logic        valid_b;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_mem [8];
    logic [15:0] hold_a;
    logic [15:0] hold_b;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_mem[i] = '0;
        hold_a = '0;
        hold_b = '0;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] ra, input logic we,
                                               input logic [2:0] wa, input logic [15:0] wd);
        logic [15:0] v;
        v = (ra == 3'd0) ? 16'h0000 : model_mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (we && (wa == ra) && (ra != 3'd0)) v = wd;
`endif
        return v;
    endfunction

    // Drives one cycle of stimulus just after an edge, pushes the model's expectation,
    // then compares the DUT outputs 1 ns after the next rising edge.
    task automatic cycle(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic rea, input logic [2:0] aa,
                         input logic reb, input logic [2:0] ab, input string tag);
        exp_t e;
        exp_t got;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_a = rea; rd_addr_a = aa;
        rd_en_b = reb; rd_addr_b = ab;
        if (rea) hold_a = model_read(aa, we, wa, wd);
        if (reb) hold_b = model_read(ab, we, wa, wd);
        e.tag = tag; e.data_a = hold_a; e.valid_a = rea; e.data_b = hold_b; e.valid_b = reb;
        exp_q.push_back(e);
        if (we && (wa != 3'd0)) model_mem[wa] = wd;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({got.tag, "_data_a"}, rd_data_a, got.data_a);
        check({got.tag, "_valid_a"}, {15'b0, rd_valid_a}, {15'b0, got.valid_a});
        check({got.tag, "_data_b"}, rd_data_b, got.data_b);
        check({got.tag, "_valid_b"}, {15'b0, rd_valid_b}, {15'b0, got.valid_b});
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en_a = 1'b0; rd_addr_a = '0;
        rd_en_b = 1'b0; rd_addr_b = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_a"}, rd_data_a, 16'h0000);
        check({tag, "_valid_a"}, {15'b0, rd_valid_a}, 16'h0000);
        check({tag, "_data_b"}, rd_data_b, 16'h0000);
        check({tag, "_valid_b"}, {15'b0, rd_valid_b}, 16'h0000);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        model_reset();

        #12;
        check_outputs_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Every register starts at zero after reset.
        for (int i = 1; i < 8; i++) begin
            cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(8 - i), "init_read");
        end

        // Basic write then read, then idle to check valid drops and data holds.
        cycle(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0, "wr_r3");
        cycle(1'b0, 3'd0, 16'h0,    1'b1, 3'd3, 1'b0, 3'd0, "rd_r3");
        cycle(1'b0, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 3'd0, "hold_r3");

        // Writes to r0 are dropped.
        cycle(1'b1, 3'd0, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0, "wr_r0");
        cycle(1'b0, 3'd0, 16'h0,    1'b1, 3'd0, 1'b1, 3'd0, "rd_r0");

        // Same-edge read/write hazard on r5.
        cycle(1'b1, 3'd5, 16'h0001, 1'b0, 3'd0, 1'b0, 3'd0, "wr_r5");
        cycle(1'b1, 3'd5, 16'h00FF, 1'b1, 3'd5, 1'b0, 3'd0, "raw_r5");
        cycle(1'b0, 3'd0, 16'h0,    1'b1, 3'd5, 1'b0, 3'd0, "reread_r5");

        // Same-edge write to r0 while reading r0 must still return zero.
        cycle(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b1, 3'd0, "raw_r0");

        // Dual-port independence and same-address reads.
        cycle(1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd0, 1'b0, 3'd0, "wr_r2");
        cycle(1'b1, 3'd7, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd0, "wr_r7");
        cycle(1'b0, 3'd0, 16'h0,    1'b1, 3'd2, 1'b1, 3'd7, "rd_r2_r7");
        cycle(1'b0, 3'd0, 16'h0,    1'b1, 3'd7, 1'b1, 3'd7, "rd_r7_r7");

        // Asynchronous reset mid-cycle while outputs are nonzero.
        idle_inputs();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd7, "post_rst_read");

        // Reset asserted while a write to r4 is being presented.
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hCAFE;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b1, 3'd4, "rst_during_wr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Register file built on write-enabled edge storage words.
- Consumes the per-bit write-enable flip-flop style storage as its downstream user.
- One write port and two registered read ports.
- Feeds the ALU operand stage of the datapath; register 0 reads as constant zero.

Parameters:
- WIDTH, 16, bits per register word.
- DEPTH, 8, number of registers; must be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request, sampled on rising clk.
- wr_addr  input  ADDR_W  write register index.
- wr_data  input  WIDTH  write data.
- rd_en_a  input  1  port A read request.
- rd_addr_a  input  ADDR_W  port A register index.
- rd_data_a  output  WIDTH  port A registered read data.
- rd_valid_a  output  1  port A data valid, one cycle after request.
- rd_en_b  input  1  port B read request.
- rd_addr_b  input  ADDR_W  port B register index.
- rd_data_b  output  WIDTH  port B registered read data.
- rd_valid_b  output  1  port B data valid.

Behaviour:
- Reset: rst_n low clears all registers, rd_data_a/b and rd_valid_a/b to 0 immediately, independent of clk.
- Reset may assert mid-operation. Any write or read in flight is discarded. First accepted operation is on the first rising clk with rst_n high.
- Write: on rising clk with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Visible to reads issued on the following edge.
- Writes to address 0 are dropped; reg[0] stays 0.
- Read latency is 1 cycle. On rising clk with rd_en_x=1, rd_data_x <= reg[rd_addr_x] and rd_valid_x <= 1.
- With rd_en_x=0, rd_valid_x <= 0 and rd_data_x holds its last value.
- Read of address 0 always returns 0.
- Ports A and B are fully independent. Both ports may read the same address in the same cycle and get identical data.
- Read and write to the same nonzero address on the same edge (feature off): read returns the pre-write value.
- No handshake back-pressure: every request is accepted every cycle.
- All addresses are in range because DEPTH is a power of two. No error path.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: on an edge with wr_en=1, wr_addr==rd_addr_x!=0 and rd_en_x=1, rd_data_x <= wr_data (write-through forwarding). Removes the one-cycle read-after-write hazard. Address 0 still returns 0.
- Undefined: no forwarding; the pre-write value is returned as stated above.
- Storage contents are identical in both builds.

Decomposition:
- Package regfile_pkg:
  - REG_ZERO index constant (0).
  - Default WIDTH/DEPTH constants.
  - Typedefs for word (logic [WIDTH-1:0]) and address (logic [ADDR_W-1:0]).
- Sub-module reg_word: one WIDTH-bit register with write enable and async active-low clear. Instantiated DEPTH-1 times (index 1..DEPTH-1); index 0 is tied to zero.
- Write decoder and read muxes stay in the top level.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with outputs nonzero -> rd_data_a/b=0 and rd_valid_a/b=0 immediately. Reads of regs 1..7 after release return 0.
- Basic write/read: write 16'hBEEF to r3. Next cycle rd_en_a=1, rd_addr_a=3 -> one cycle later rd_data_a=16'hBEEF, rd_valid_a=1. Following cycle with rd_en_a=0 -> rd_valid_a=0, data held at 16'hBEEF.
- Zero register: write 16'h1234 to r0, then read r0 on both ports -> rd_data_a=rd_data_b=0.
- Same-edge hazard: r5=16'h0001; on one edge write r5=16'h00FF and read r5 on port A -> 16'h0001 without REGFILE_BYPASS_EN, 16'h00FF with it. The next read returns 16'h00FF in both builds.
- Dual port: r2=16'hAAAA, r7=16'h5555; same cycle read A=2, B=7 -> 16'hAAAA / 16'h5555. Then read A=B=7 -> both 16'h5555.
- Reset during write: assert rst_n=0 in the cycle wr_en=1, wr_addr=4, wr_data=16'hCAFE -> after release, read r4 = 0.
